// File: rtl/tinydcim_mac_array.sv
// -----------------------------------------------------------------------------
// tinydcim_mac_array
//
// Digital compute-in-memory dot-product engine. ROWS signed weights and ROWS
// activations live in local register files loaded through a byte-wide write
// port. On start the engine computes sum(w[i]*a[i]) bit-serially over the
// activation bits, MSB first, one bit-plane per clock. The result is offered
// on a valid/ready port.
//
// Parameters:
//   ROWS     number of weight/activation pairs (power of two, 2..16)
//   W_BITS   weight width, two's complement (2..8)
//   A_BITS   activation width (2..8)
//   A_SIGNED 1 = activations two's complement, 0 = unsigned
//   ACC_W    result width (derived, not overridable)
//
// Ports:
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   wr_en/wr_sel        write strobe; 0 = weight file, 1 = activation file
//   wr_addr/wr_data     entry index and byte data (low W_BITS/A_BITS used)
//   start               begin a dot product (accepted in IDLE only)
//   busy                high while computing or holding a result
//   res_valid/res_ready result handshake
//   res_data            signed dot-product result
//
// Build option:
//   TINYDCIM_RELU_EN    when defined, negative results are clamped to zero as
//                       the result is captured; the accumulation is unchanged.
// -----------------------------------------------------------------------------
module tinydcim_mac_array #(
    parameter  int ROWS     = 4,
    parameter  int W_BITS   = 4,
    parameter  int A_BITS   = 4,
    parameter  int A_SIGNED = 1,
    localparam int ACC_W    = W_BITS + A_BITS + $clog2(ROWS)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_en,
    input  logic                    wr_sel,
    input  logic [$clog2(ROWS)-1:0] wr_addr,
    input  logic [7:0]              wr_data,
    input  logic                    start,
    output logic                    busy,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [ACC_W-1:0]        res_data
);

    localparam int BIT_W = $clog2(A_BITS);
    localparam logic [BIT_W-1:0] TOP_BIT = BIT_W'(A_BITS - 1);
    localparam logic [BIT_W-1:0] BIT_ONE = BIT_W'(1'b1);
    localparam logic [BIT_W-1:0] BIT_ZERO = BIT_W'(1'b0);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    state_t                    state_q, state_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic [BIT_W-1:0]          bit_q, bit_d;
    logic                      busy_q, busy_d;
    logic                      valid_q, valid_d;
    logic [ACC_W-1:0]          res_data_q, res_data_d;
    logic [W_BITS-1:0]         weight_q [ROWS];
    logic [W_BITS-1:0]         weight_d [ROWS];
    logic [A_BITS-1:0]         act_q [ROWS];
    logic [A_BITS-1:0]         act_d [ROWS];

    logic signed [ACC_W-1:0]   plane_s;
    logic signed [ACC_W-1:0]   acc_shift_s;
    logic signed [ACC_W-1:0]   acc_step_s;
    logic                      unused_s;

    // Upper write-data bits beyond the entry widths are intentionally ignored.
    assign unused_s = ^wr_data;

    // Sign-extend a weight to accumulator width.
    function automatic logic signed [ACC_W-1:0] sext_w(input logic [W_BITS-1:0] w);
        return {{(ACC_W - W_BITS){w[W_BITS-1]}}, w};
    endfunction

    // Optional clamp applied only when the result is captured.
    function automatic logic [ACC_W-1:0] clamp_result(input logic [ACC_W-1:0] v);
`ifdef TINYDCIM_RELU_EN
        if (v[ACC_W-1]) begin
            return {ACC_W{1'b0}};
        end else begin
            return v;
        end
`else
        return v;
`endif
    endfunction

    // Bit-plane partial sum: rows whose current activation bit is set
    // contribute their sign-extended weight (adder tree across rows).
    always_comb begin
        plane_s = {ACC_W{1'b0}};
        for (int i = 0; i < ROWS; i++) begin
            if (act_q[i][bit_q]) begin
                plane_s = plane_s + sext_w(weight_q[i]);
            end else begin
                plane_s = plane_s;
            end
        end
    end

    // Shift-and-add step; the MSB plane of a signed activation carries
    // negative weight, so it is subtracted instead of added.
    always_comb begin
        acc_shift_s = {acc_q[ACC_W-2:0], 1'b0};
        if ((A_SIGNED != 32'sd0) && (bit_q == TOP_BIT)) begin
            acc_step_s = acc_shift_s - plane_s;
        end else begin
            acc_step_s = acc_shift_s + plane_s;
        end
    end

    // Next-state logic for the controller, register files and result port.
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        bit_d      = bit_q;
        valid_d    = valid_q;
        res_data_d = res_data_q;
        weight_d   = weight_q;
        act_d      = act_q;

        case (state_q)
            ST_IDLE: begin
                // A write coinciding with start still lands before the
                // first plane is read on the following edge.
                if (wr_en) begin
                    if (wr_sel) begin
                        act_d[wr_addr] = wr_data[A_BITS-1:0];
                    end else begin
                        weight_d[wr_addr] = wr_data[W_BITS-1:0];
                    end
                end else begin
                    weight_d = weight_q;
                end
                if (start) begin
                    acc_d   = {ACC_W{1'b0}};
                    bit_d   = TOP_BIT;
                    state_d = ST_COMPUTE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_COMPUTE: begin
                acc_d = acc_step_s;
                if (bit_q == BIT_ZERO) begin
                    state_d    = ST_DONE;
                    valid_d    = 1'b1;
                    res_data_d = clamp_result(acc_step_s);
                end else begin
                    bit_d = bit_q - BIT_ONE;
                end
            end
            ST_DONE: begin
                if (res_ready) begin
                    valid_d = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    valid_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and storage registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            acc_q      <= {ACC_W{1'b0}};
            bit_q      <= BIT_ZERO;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            res_data_q <= {ACC_W{1'b0}};
            for (int i = 0; i < ROWS; i++) begin
                weight_q[i] <= {W_BITS{1'b0}};
                act_q[i]    <= {A_BITS{1'b0}};
            end
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            bit_q      <= bit_d;
            busy_q     <= busy_d;
            valid_q    <= valid_d;
            res_data_q <= res_data_d;
            weight_q   <= weight_d;
            act_q      <= act_d;
        end
    end

    assign busy      = busy_q;
    assign res_valid = valid_q;
    assign res_data  = res_data_q;

endmodule

// File: tb/tb_tinydcim_mac_array.sv
// Bench for tinydcim_mac_array. Two instances share all inputs: one with
// signed activations (default) and one with unsigned activations.
module tb_tinydcim_mac_array;

    localparam int ROWS   = 4;
    localparam int A_BITS = 4;
    localparam int ACC_W  = 10;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             wr_en;
    logic             wr_sel;
    logic [1:0]       wr_addr;
    logic [7:0]       wr_data;
    logic             start;
    logic             res_ready;
    logic             busy_s, valid_s, busy_u, valid_u;
    logic [ACC_W-1:0] data_s, data_u;

    int n_chk  = 0;
    int n_fail = 0;

    logic [3:0] mw [ROWS];
    logic [3:0] ma [ROWS];

    typedef struct packed {
        logic [15:0] w;
        logic [15:0] a;
        int          es;
        int          eu;
    } vec_t;

    vec_t tbl [5];

    tinydcim_mac_array #(.ROWS(4), .W_BITS(4), .A_BITS(4), .A_SIGNED(1)) u_dut_s (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_sel(wr_sel),
        .wr_addr(wr_addr), .wr_data(wr_data), .start(start), .busy(busy_s),
        .res_valid(valid_s), .res_ready(res_ready), .res_data(data_s)
    );

    tinydcim_mac_array #(.ROWS(4), .W_BITS(4), .A_BITS(4), .A_SIGNED(0)) u_dut_u (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_sel(wr_sel),
        .wr_addr(wr_addr), .wr_data(wr_data), .start(start), .busy(busy_u),
        .res_valid(valid_u), .res_ready(res_ready), .res_data(data_u)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int relu(input int v);
`ifdef TINYDCIM_RELU_EN
        return (v < 0) ? 0 : v;
`else
        return v;
`endif
    endfunction

    // Reference dot product straight from the stored entries.
    function automatic int model(input bit a_signed);
        int sum = 0;
        for (int i = 0; i < ROWS; i++) begin
            int wv = int'($signed(mw[i]));
            int av = a_signed ? int'($signed(ma[i])) : int'(ma[i]);
            sum += wv * av;
        end
        return sum;
    endfunction

    // All tasks are entered and left just after a falling edge.
    task automatic wr(input bit sel, input int addr, input logic [3:0] val);
        wr_en   = 1'b1;
        wr_sel  = sel;
        wr_addr = addr[1:0];
        wr_data = {4'($urandom_range(0, 15)), val};
        @(negedge clk);
        wr_en = 1'b0;
        if (sel) ma[addr] = val;
        else     mw[addr] = val;
    endtask

    task automatic load(input logic [15:0] w, input logic [15:0] a);
        for (int i = 0; i < ROWS; i++) begin
            wr(1'b0, i, w[4*i +: 4]);
            wr(1'b1, i, a[4*i +: 4]);
        end
    endtask

    task automatic check_result(input string nm, input int es, input int eu);
        chk({nm, "_signed"}, $signed(data_s), relu(es));
        chk({nm, "_unsigned"}, $signed(data_u), relu(eu));
    endtask

    // Start, check busy and exact latency, check result; no handshake.
    task automatic compute(input int es, input int eu, input bit early, input bit wr_a3);
        start     = 1'b1;
        res_ready = early;
        if (wr_a3) begin
            wr_en   = 1'b1;
            wr_sel  = 1'b1;
            wr_addr = 2'd3;
            wr_data = 8'h02;
            ma[3]   = 4'd2;
        end
        @(negedge clk);
        start = 1'b0;
        wr_en = 1'b0;
        chk("busy_after_start", {busy_s, busy_u}, 3);
        chk("valid_after_start", {valid_s, valid_u}, 0);
        for (int c = 1; c <= A_BITS; c++) begin
            @(negedge clk);
            chk("busy_compute", {busy_s, busy_u}, 3);
            chk("valid_timing", {valid_s, valid_u}, (c == A_BITS) ? 3 : 0);
        end
        check_result("result", es, eu);
    endtask

    task automatic handshake(input int es, input int eu);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk("valid_after_hs", {valid_s, valid_u}, 0);
        chk("busy_after_hs", {busy_s, busy_u}, 0);
        check_result("data_held_after_hs", es, eu);
    endtask

    initial begin
        tbl[0] = '{w: 16'h4321, a: 16'h1111, es: 10,   eu: 10};
        tbl[1] = '{w: 16'h8888, a: 16'h8888, es: 256,  eu: -256};
        tbl[2] = '{w: 16'h7777, a: 16'h8888, es: -224, eu: 224};
        tbl[3] = '{w: 16'h307F, a: 16'h20FF, es: 0,    eu: 96};
        tbl[4] = '{w: 16'h8888, a: 16'h7777, es: -224, eu: -224};

        for (int i = 0; i < ROWS; i++) begin
            mw[i] = 4'd0;
            ma[i] = 4'd0;
        end
        rst_n = 1'b0; wr_en = 1'b0; wr_sel = 1'b0; wr_addr = 2'd0;
        wr_data = 8'd0; start = 1'b0; res_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_busy", {busy_s, busy_u}, 0);
        chk("reset_valid", {valid_s, valid_u}, 0);
        check_result("reset_data", 0, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Table of directed vectors.
        for (int t = 0; t < 5; t++) begin
            load(tbl[t].w, tbl[t].a);
            compute(tbl[t].es, tbl[t].eu, 1'b0, 1'b0);
            handshake(tbl[t].es, tbl[t].eu);
        end

        // Backpressure: result held, start and writes ignored while waiting.
        load(16'h4321, 16'h1111);
        compute(10, 10, 1'b0, 1'b0);
        for (int c = 0; c < 10; c++) begin
            if (c == 3) start = 1'b1;
            if (c == 5) begin
                wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 2'd0; wr_data = 8'h05;
            end
            @(negedge clk);
            start = 1'b0;
            wr_en = 1'b0;
            chk("bp_valid", {valid_s, valid_u}, 3);
            chk("bp_busy", {busy_s, busy_u}, 3);
            check_result("bp_data", 10, 10);
        end
        handshake(10, 10);
        compute(10, 10, 1'b0, 1'b0);
        handshake(10, 10);

        // Write and start in the same cycle.
        load(16'h1111, 16'h0000);
        compute(2, 2, 1'b0, 1'b1);
        handshake(2, 2);

        // Randomized against the reference model; odd runs hold res_ready
        // high from start, which must not disturb anything before valid.
        for (int it = 0; it < 40; it++) begin
            logic [15:0] rw, ra;
            int es, eu;
            rw = 16'($urandom);
            ra = 16'($urandom);
            load(rw, ra);
            es = model(1'b1);
            eu = model(1'b0);
            compute(es, eu, it[0], 1'b0);
            handshake(es, eu);
        end

        // Reset during the second compute cycle aborts and clears storage.
        load(16'h4321, 16'h7777);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", {busy_s, busy_u}, 0);
        chk("abort_valid", {valid_s, valid_u}, 0);
        check_result("abort_data", 0, 0);
        for (int i = 0; i < ROWS; i++) begin
            mw[i] = 4'd0;
            ma[i] = 4'd0;
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        compute(model(1'b1), model(1'b0), 1'b0, 1'b0);
        handshake(model(1'b1), model(1'b0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
